// File: rtl/switch_cfg_loader.sv
// Routing-entry frame loader: validates entries into a shadow, commits atomically to cfg_out.
// Optional trailing XOR checksum word: define CFG_CHECKSUM_EN.
module switch_cfg_loader #(
    parameter int NTB = 5,
    parameter int NLR = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [5:0]                     din,
    input  logic                           din_valid,
    output logic                           din_ready,
    output logic [6*(2*NTB+2*NLR)-1:0]     cfg_out,
    output logic                           cfg_commit,
    output logic                           busy,
    output logic                           err
);

    localparam int NENT = 2*NTB + 2*NLR;
    localparam int CW   = $clog2(NENT);
    localparam int W    = 6*NENT;

    localparam logic [CW-1:0] C_BOT  = CW'(NTB);
    localparam logic [CW-1:0] C_LEFT = CW'(2*NTB);
    localparam logic [CW-1:0] C_RGT  = CW'(2*NTB+NLR);
    localparam logic [CW-1:0] C_LAST = CW'(NENT-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_shadow;
    logic [W-1:0]   r_cfg;
    logic           r_err;
    logic [W-1:0]   w_shadow_nxt;
    logic           w_xfer;
    logic           w_last;
    logic           w_go_commit;
    logic [2:0]     w_side;
    logic [3:0]     w_idx;
    logic [2:0]     w_dside;
    logic [3:0]     w_didx;
    logic [CW-1:0]  w_off;
    logic           w_rng_ok;
    logic           w_ok;
    logic [5:0]     w_word;
    logic           w_csum_ok;
`ifdef CFG_CHECKSUM_EN
    logic [5:0]     r_csum;
`endif

    assign w_xfer = din_valid && din_ready;
    assign w_last = (r_cnt == C_LAST);
    assign w_side = din[2:0];
    assign w_idx  = {1'b0, din[5:3]};

`ifdef CFG_CHECKSUM_EN
    assign w_csum_ok = (din == r_csum);
`else
    assign w_csum_ok = 1'b1;
`endif

    // Destination pin (side, index) of the entry currently being loaded
    always_comb begin
        w_dside = 3'd2;
        w_off   = r_cnt - C_RGT;
        if (r_cnt < C_BOT) begin
            w_dside = 3'd1;
            w_off   = r_cnt;
        end else if (r_cnt < C_LEFT) begin
            w_dside = 3'd3;
            w_off   = r_cnt - C_BOT;
        end else if (r_cnt < C_RGT) begin
            w_dside = 3'd4;
            w_off   = r_cnt - C_LEFT;
        end
        w_didx = 4'(w_off);
    end

    // Entry validation: side code, index range, self-loop
    always_comb begin
        w_rng_ok = 1'b0;
        unique case (w_side)
            3'd0:       w_rng_ok = 1'b1;
            3'd1, 3'd3: w_rng_ok = (w_idx < 4'(NTB));
            3'd2, 3'd4: w_rng_ok = (w_idx < 4'(NLR));
            default:    w_rng_ok = 1'b0;
        endcase
        w_ok   = w_rng_ok && !((w_side == w_dside) && (w_idx == w_didx));
        w_word = w_ok ? din : 6'd0;
    end

    // Shadow image including the entry being written this cycle
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (r_cnt <= C_LAST)
            w_shadow_nxt[6*int'(r_cnt) +: 6] = w_word;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD: begin
                if (start)
                    w_next = S_LOAD;
                else if (w_xfer && w_last)
`ifdef CFG_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_COMMIT;
`endif
            end
            S_CHECK: begin
                if (start)
                    w_next = S_LOAD;
                else if (w_xfer)
                    w_next = w_csum_ok ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: w_next = start ? S_LOAD : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        din_ready  = ((r_state == S_LOAD) || (r_state == S_CHECK)) && !start;
        cfg_commit = (r_state == S_COMMIT);
        busy       = (r_state != S_IDLE);
    end

    assign w_go_commit = (r_state != S_COMMIT) && (w_next == S_COMMIT);
    assign cfg_out     = r_cfg;
    assign err         = r_err;

    // Frame datapath: shadow, counter, sticky error, active config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_cfg    <= '0;
            r_err    <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            r_csum   <= '0;
`endif
        end else begin
            if (w_go_commit)
                r_cfg <= (r_state == S_LOAD) ? w_shadow_nxt : r_shadow;
            if (start) begin
                r_cnt    <= '0;
                r_shadow <= '0;
                r_err    <= 1'b0;
`ifdef CFG_CHECKSUM_EN
                r_csum   <= '0;
`endif
            end else if (w_xfer && r_state == S_LOAD) begin
                r_shadow <= w_shadow_nxt;
                r_cnt    <= r_cnt + 1'b1;
                if (!w_ok)
                    r_err <= 1'b1;
`ifdef CFG_CHECKSUM_EN
                r_csum   <= r_csum ^ din;
`endif
            end else if (w_xfer && r_state == S_CHECK) begin
                if (!w_csum_ok)
                    r_err <= 1'b1;
            end
        end
    end

endmodule
